dsp48a1_mac_seq: RTL and testbench
==================================

Name: dsp48a1_mac_seq

Overview:
Sequencer that drives a DSP48A1 slice as a multiply-accumulate engine for dot products. It accepts a job command (pair count), then streams (A,B) operand pairs into the slice. It generates OPMODE with the correct pipeline skew and captures the final P value as a 48-bit result. It is the initiator/driver side of the DSP48A1 port interface and sits between a stream source and the DSP48A1 instance.

Parameters:
LEN_W, 16, width of the job length field (pairs per job, 0..2^LEN_W-1)
DSP_LAT, 3, cycles from an operand handshake to P reflecting it (A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0, B_INPUT="DIRECT", CARRYINSEL="OPMODE5", RSTTYPE="SYNC")

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
cmd_valid  in  1  job request
cmd_ready  out  1  job accepted when cmd_valid&&cmd_ready
cmd_len  in  LEN_W  number of operand pairs in the job
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted when in_valid&&in_ready
in_a  in  18  multiplicand (unsigned)
in_b  in  18  multiplier (unsigned)
res_valid  out  1  result valid
res_ready  in  1  result consumed when res_valid&&res_ready
res_data  out  48  accumulated sum mod 2^48
busy  out  1  high in any state other than IDLE
dsp_A  out  18  to DSP48A1 A
dsp_B  out  18  to DSP48A1 B
dsp_OPMODE  out  8  to DSP48A1 OPMODE
dsp_RST  out  1  to all DSP48A1 RST* inputs
dsp_P  in  48  from DSP48A1 P

Integrator ties all DSP CE* high, and ties D, C, PCIN, BCIN and CARRYIN to 0.

Behaviour:
- Reset: RST is synchronous and active-high; dsp_RST = RST combinationally. Reset values:
  - state=IDLE, cmd_ready=1, in_ready=0, res_valid=0, res_data=0, busy=0
  - dsp_OPMODE=8'h08, dsp_A=0, dsp_B=0
- States:
  - IDLE: cmd_ready=1. On cmd handshake: len==0 -> DONE with res_data=0; else latch remaining=cmd_len, first=1 -> ACC.
  - ACC: in_ready=1. Each handshake decrements remaining and clears first. Handshake with remaining==1 -> DRAIN and loads drain counter.
  - DRAIN: in_ready=0. Counts DSP_LAT cycles after the last handshake cycle. On the edge ending the DSP_LAT-th cycle, captures res_data<=dsp_P -> DONE.
  - DONE: res_valid=1, res_data stable. On res_ready -> IDLE.
- Operand drive: dsp_A=in_a and dsp_B=in_b combinationally in ACC; 0 in all other states. The slice's A1/B1 registers supply the input stage.
- OPMODE skew: dsp_OPMODE is registered and reflects the issue status of the previous cycle. It lines up with M through OPMODEREG.
  - Previous cycle handshake with first=1 -> 8'h01 (X=M, Z=0, add, pre-adder bypassed, carry 0).
  - Previous cycle handshake with first=0 -> 8'h09 (X=M, Z=P).
  - No handshake -> 8'h08 (X=0, Z=P; P holds).
- Timing: last handshake in cycle t -> P valid in cycle t+3 -> res_valid high from cycle t+4.
- Bubbles (in_valid low in ACC) insert hold OPMODEs and do not corrupt the sum.
- Arithmetic: unsigned 18x18 product zero-extended to 48 bits. The sum wraps mod 2^48 with no overflow flag.
- The first pair of each job uses Z=0, so the previous job's P never leaks into the next result.
- cmd_ready is 0 outside IDLE; commands in other states are ignored, not queued.
- If the cmd handshake and in_valid coincide in IDLE, the operand is not accepted; in_ready rises in the next cycle.
- RST in any state aborts the job immediately and returns all reset values on the next edge. Operands in flight are discarded and the slice registers are cleared.

Test Plan:
- Hold RST 2 cycles with random inputs -> every output at its reset value, dsp_OPMODE=8'h08, dsp_RST=1; release -> cmd_ready=1.
- cmd_len=3, pairs (2,3),(4,5),(6,7) back-to-back -> OPMODE sequence 01,09,09,08; res_data=68; res_valid rises exactly 4 cycles after the 3rd handshake.
- cmd_len=2, pair (100,200), 5-cycle in_valid gap, then (1,1) -> res_data=20001. Repeat the job with RST pulsed mid-gap -> IDLE, no res_valid.
- Hold res_ready=0 for 10 cycles after the previous result -> res_data stable, cmd_ready=0. Then release and run a job with cmd_len=1, pair (3,3) -> res_data=9.
- cmd_len=0 -> res_valid in the cycle after the handshake with res_data=0; no operand is accepted.
- cmd_len=4097, all pairs (18'h3FFFF,18'h3FFFF) -> res_data=48'h000F_7FF8_1001 (wrapped sum).

Source files
------------

// File: rtl/dsp48a1_mac_seq.sv
// ---------------------------------------------------------------------------
// dsp48a1_mac_seq
//
// Multiply-accumulate sequencer driving a DSP48A1 slice to compute unsigned
// dot products. A job command carries the number of (A,B) operand pairs; the
// pairs are streamed straight into the slice's A1/B1 registers, OPMODE is
// issued one cycle behind each operand so it meets the product at the M
// register, and the final P value is captured as the 48-bit result.
//
// Expected slice configuration: A1REG=B1REG=MREG=PREG=OPMODEREG=1,
// A0REG=B0REG=0, B_INPUT="DIRECT", CARRYINSEL="OPMODE5", RSTTYPE="SYNC",
// all CE* tied high, D/C/PCIN/BCIN/CARRYIN tied to 0.
//
// Ports
//   CLK         in   1      rising-edge clock
//   RST         in   1      synchronous active-high reset
//   cmd_valid   in   1      job request
//   cmd_ready   out  1      job accepted on cmd_valid && cmd_ready (IDLE only)
//   cmd_len     in   LEN_W  operand pairs in the job (0 allowed)
//   in_valid    in   1      operand pair valid
//   in_ready    out  1      operand pair accepted on in_valid && in_ready
//   in_a        in   18     unsigned multiplicand
//   in_b        in   18     unsigned multiplier
//   res_valid   out  1      result valid
//   res_ready   in   1      result consumed on res_valid && res_ready
//   res_data    out  48     accumulated sum mod 2^48
//   busy        out  1      high whenever the sequencer is not idle
//   dsp_A       out  18     to slice A
//   dsp_B       out  18     to slice B
//   dsp_OPMODE  out  8      to slice OPMODE
//   dsp_RST     out  1      to every slice RST* input
//   dsp_P       in   48     from slice P
// ---------------------------------------------------------------------------
module dsp48a1_mac_seq #(
  parameter int LEN_W   = 16,
  parameter int DSP_LAT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             busy,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_RST,
  input  logic [47:0]      dsp_P
);

  // Drain counter must hold values up to DSP_LAT-1.
  localparam int CNT_W = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;

  // OPMODE encodings: X = opmode[1:0], Z = opmode[3:2].
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0: start a fresh sum
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P: accumulate
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P: P holds its value

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [LEN_W-1:0]   remaining_r;
  logic [LEN_W-1:0]   remaining_s;
  logic               first_r;
  logic               first_s;
  logic [CNT_W-1:0]   drain_cnt_r;
  logic [CNT_W-1:0]   drain_cnt_s;
  logic [47:0]        res_data_s;
  logic [7:0]         opmode_s;
  logic               cmd_hs_s;
  logic               in_hs_s;

  // Selects the OPMODE that must meet an operand at the slice's M register.
  function automatic logic [7:0] opmode_for(input logic issued, input logic first);
    logic [7:0] op;
    if (issued) begin
      if (first) begin
        op = OPM_FIRST;
      end else begin
        op = OPM_ACC;
      end
    end else begin
      op = OPM_HOLD;
    end
    return op;
  endfunction

  assign cmd_hs_s = cmd_valid && cmd_ready;
  assign in_hs_s  = in_valid && in_ready;

  // The slice shares our synchronous reset so in-flight products are flushed.
  assign dsp_RST = RST;

  // Operands go straight to the slice input registers while accumulating.
  always_comb begin
    dsp_A = 18'd0;
    dsp_B = 18'd0;
    if (state_r == ACC) begin
      dsp_A = in_a;
      dsp_B = in_b;
    end else begin
      dsp_A = 18'd0;
      dsp_B = 18'd0;
    end
  end

  // Next-state, job bookkeeping and result capture.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    first_s     = first_r;
    drain_cnt_s = drain_cnt_r;
    res_data_s  = res_data;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s) begin
          if (cmd_len == '0) begin
            state_s    = DONE;
            res_data_s = 48'd0;
          end else begin
            state_s     = ACC;
            remaining_s = cmd_len;
            first_s     = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (in_hs_s) begin
          remaining_s = remaining_r - LEN_W'(1);
          first_s     = 1'b0;
          if (remaining_r == LEN_W'(1)) begin
            // The last pair still needs DSP_LAT cycles to reach P.
            state_s     = DRAIN;
            drain_cnt_s = CNT_W'(DSP_LAT - 1);
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == '0) begin
          res_data_s = dsp_P;
          state_s    = DONE;
        end else begin
          drain_cnt_s = drain_cnt_r - CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // OPMODE is one cycle behind the operand handshake to line up with M.
  always_comb begin
    opmode_s = opmode_for(in_hs_s, first_r);
  end

  // State, bookkeeping and all registered outputs; flags decode the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      remaining_r <= '0;
      first_r     <= 1'b0;
      drain_cnt_r <= '0;
      res_data    <= 48'd0;
      dsp_OPMODE  <= OPM_HOLD;
      cmd_ready   <= 1'b1;
      in_ready    <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      first_r     <= first_s;
      drain_cnt_r <= drain_cnt_s;
      res_data    <= res_data_s;
      dsp_OPMODE  <= opmode_s;
      cmd_ready   <= (state_s == IDLE);
      in_ready    <= (state_s == ACC);
      res_valid   <= (state_s == DONE);
      busy        <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_dsp48a1_mac_seq
//
// Directed and randomized bench for dsp48a1_mac_seq. A cycle-level model of
// the configured DSP48A1 slice closes the loop on dsp_P; expected sums come
// from plain arithmetic over the operand list of each job.
// ---------------------------------------------------------------------------
module tb_dsp48a1_mac_seq;

  localparam int LEN_W = 16;

  logic             CLK = 1'b0;
  logic             RST;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;
  logic             busy;
  logic [17:0]      dsp_A;
  logic [17:0]      dsp_B;
  logic [7:0]       dsp_OPMODE;
  logic             dsp_RST;
  logic [47:0]      dsp_P;

  always #5 CLK = ~CLK;

  dsp48a1_mac_seq #(.LEN_W(LEN_W), .DSP_LAT(3)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE),
    .dsp_RST(dsp_RST), .dsp_P(dsp_P)
  );

  // Slice model: A1/B1 -> M -> P, OPMODE through OPMODEREG, sync reset.
  logic [17:0] a1_m, b1_m;
  logic [35:0] m_m;
  logic [7:0]  op_m;
  logic [47:0] p_m;
  assign dsp_P = p_m;

  always_ff @(posedge CLK) begin
    if (dsp_RST) begin
      a1_m <= 18'd0; b1_m <= 18'd0; m_m <= 36'd0; op_m <= 8'd0; p_m <= 48'd0;
    end else begin
      a1_m <= dsp_A;
      b1_m <= dsp_B;
      m_m  <= 36'(a1_m) * 36'(b1_m);
      op_m <= dsp_OPMODE;
      p_m  <= ((op_m[1:0] == 2'b01) ? {12'd0, m_m} : 48'd0)
            + ((op_m[3:2] == 2'b10) ? p_m : 48'd0);
    end
  end

  int checks   = 0;
  int failures = 0;

  logic [17:0] qa[$];
  logic [17:0] qb[$];
  int gap_idx  = -1;
  int gap_len  = 0;
  bit rand_bub = 1'b0;
  int hold     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_job(input int len);
    logic [47:0] exp_sum;
    logic [7:0]  exp_op;
    int idx, budget, gap_cnt;
    bit first, bub, hs;
    exp_sum = 48'd0;
    for (int i = 0; i < len; i++) exp_sum = exp_sum + 48'(qa[i]) * 48'(qb[i]);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    in_valid  = 1'b1;
    in_a      = (len > 0) ? qa[0] : 18'($urandom);
    in_b      = (len > 0) ? qb[0] : 18'($urandom);
    #1;
    chk("cmd_cycle_in_ready", in_ready, 0);
    tick;
    cmd_valid = 1'b0;
    cmd_len   = LEN_W'($urandom);
    if (len == 0) begin
      chk("len0_res_valid", res_valid, 1);
      chk("len0_in_ready", in_ready, 0);
      chk("len0_busy", busy, 1);
      chk("len0_opmode", dsp_OPMODE, 8'h08);
    end else begin
      chk("acc_in_ready", in_ready, 1);
      chk("acc_cmd_ready", cmd_ready, 0);
      chk("acc_first_opmode", dsp_OPMODE, 8'h08);
      idx = 0; first = 1'b1; budget = 0; gap_cnt = 0;
      while (idx < len && budget < 20000) begin
        bub = rand_bub ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (idx == gap_idx && gap_cnt < gap_len) begin
          bub = 1'b1;
          gap_cnt++;
        end
        in_valid  = !bub;
        in_a      = bub ? 18'($urandom) : qa[idx];
        in_b      = bub ? 18'($urandom) : qb[idx];
        cmd_valid = 1'($urandom_range(0, 1));
        #1;
        chk("acc_in_ready", in_ready, 1);
        chk("acc_dsp_a", dsp_A, in_a);
        chk("acc_dsp_b", dsp_B, in_b);
        hs = in_valid;
        tick;
        exp_op = hs ? (first ? 8'h01 : 8'h09) : 8'h08;
        chk("acc_opmode", dsp_OPMODE, exp_op);
        if (hs) begin
          first = 1'b0;
          idx++;
        end
        budget++;
      end
      if (budget >= 20000) chk("stream_timeout", 64'(idx), 64'(len));
      in_valid  = 1'b0;
      cmd_valid = 1'b0;
      #1;
      for (int k = 1; k <= 3; k++) begin
        chk("drain_res_valid", res_valid, 0);
        chk("drain_in_ready", in_ready, 0);
        chk("drain_busy", busy, 1);
        chk("drain_dsp_a", dsp_A, 0);
        if (k > 1) chk("drain_opmode", dsp_OPMODE, 8'h08);
        tick;
      end
      chk("res_latency", res_valid, 1);
    end
    chk("res_data", res_data, exp_sum);
    chk("done_cmd_ready", cmd_ready, 0);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      tick;
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, exp_sum);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("post_res_valid", res_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset with random inputs.
    RST = 1'b1; cmd_valid = 1'($urandom); cmd_len = LEN_W'($urandom);
    in_valid = 1'($urandom); in_a = 18'($urandom); in_b = 18'($urandom);
    res_ready = 1'($urandom);
    tick;
    tick;
    chk("rst_dsp_rst", dsp_RST, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_opmode", dsp_OPMODE, 8'h08);
    chk("rst_dsp_a", dsp_A, 0);
    chk("rst_dsp_b", dsp_B, 0);
    RST = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    tick;
    chk("rel_dsp_rst", dsp_RST, 0);
    chk("rel_cmd_ready", cmd_ready, 1);

    // Three pairs back to back: 6+20+42.
    qa = {18'd2, 18'd4, 18'd6}; qb = {18'd3, 18'd5, 18'd7};
    run_job(3);
    chk("sum68_model", res_data, 48'd68);

    // Bubble gap before the second pair.
    qa = {18'd100, 18'd1}; qb = {18'd200, 18'd1};
    gap_idx = 1; gap_len = 5;
    run_job(2);
    chk("sum20001_model", res_data, 48'd20001);
    gap_idx = -1; gap_len = 0;

    // Same job aborted by RST in the middle of the gap.
    cmd_valid = 1'b1; cmd_len = LEN_W'(2);
    tick;
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_a = 18'd100; in_b = 18'd200;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    RST = 1'b1;
    #1;
    chk("abort_dsp_rst", dsp_RST, 1);
    tick;
    RST = 1'b0;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_res_data", res_data, 0);
    chk("abort_opmode", dsp_OPMODE, 8'h08);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("abort_no_res_valid", res_valid, 0);
      chk("abort_idle", cmd_ready, 1);
    end

    // Result held back by res_ready, then a single-pair job.
    qa = {18'd100, 18'd1}; qb = {18'd200, 18'd1};
    hold = 10;
    run_job(2);
    hold = 0;
    qa = {18'd3}; qb = {18'd3};
    run_job(1);
    chk("sum9_model", res_data, 48'd9);

    // Empty job.
    qa = {}; qb = {};
    run_job(0);

    // Randomized jobs with random bubbles.
    rand_bub = 1'b1;
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 20);
      qa = {}; qb = {};
      for (int i = 0; i < n; i++) begin
        qa.push_back(18'($urandom));
        qb.push_back(18'($urandom));
      end
      hold = $urandom_range(0, 3);
      run_job(n);
    end
    rand_bub = 1'b0;
    hold = 0;

    // Long job of maximum operands: sum wraps mod 2^48.
    qa = {}; qb = {};
    for (int i = 0; i < 4097; i++) begin
      qa.push_back(18'h3FFFF);
      qb.push_back(18'h3FFFF);
    end
    run_job(4097);
    chk("wrap_model", res_data, 48'h000F_7FF8_1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
